// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: raises the pipeline flush
// request and holds SR, Cause, EPC and PRId for mfc0/mtc0/eret.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID       = 32'h2021_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_epc_raw;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
    assign Req       = w_int_req | w_exc_req;

    // A flushed instruction must not commit its mtc0.
    assign w_wr_sr   = En & ~Req & (CP0Add == 5'd12);
    assign w_wr_epc  = En & ~Req & (CP0Add == 5'd14);

    assign w_epc_raw = BDIn ? (VPC - 32'd4) : VPC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= HWInt;
            if (Req) begin
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_int_req ? 5'd0 : ExcCodeIn;
                r_cause_bd  <= BDIn;
                r_epc       <= {w_epc_raw[31:2], 2'b00};
            end else begin
                if (w_wr_sr) begin
                    r_sr_im <= CP0In[15:10];
                    r_sr_ie <= CP0In[0];
                end
                // eret clears EXL even if mtc0 SR tries to set it the same cycle.
                if (EXLClr) begin
                    r_sr_exl <= 1'b0;
                end else if (w_wr_sr) begin
                    r_sr_exl <= CP0In[1];
                end
                if (w_wr_epc) begin
                    r_epc <= {CP0In[31:2], 2'b00};
                end
            end
        end
    end

    assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'b00};

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            5'd12:   CP0Out = w_sr;
            5'd13:   CP0Out = w_cause;
            5'd14:   CP0Out = r_epc;
            5'd15:   CP0Out = PRID;
            default: CP0Out = 32'd0;
        endcase
    end

    assign EPCOut    = r_epc;
    assign HandlerPC = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: hand-computed register/flush expectations.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        En;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        Req;

    int errors = 0;
    int checks = 0;

    cp0_exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .En        (En),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .HandlerPC (HandlerPC),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0Add = addr;
        #1;
        check(tag, CP0Out, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; En = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        tick;
        reset = 1'b0;

        rd("rst_sr",    5'd12, 32'h0000_0000);
        rd("rst_cause", 5'd13, 32'h0000_0000);
        rd("rst_epc",   5'd14, 32'h0000_0000);
        rd("rst_prid",  5'd15, 32'h2021_0007);
        check("rst_req", {31'd0, Req}, 32'd0);
        check("handler_pc", HandlerPC, 32'h0000_4180);

        // Plain exception
        tick;
        ExcCodeIn = 5'd10; VPC = 32'h0000_3010; BDIn = 1'b0;
        #1;
        check("exc_req", {31'd0, Req}, 32'd1);
        tick;
        rd("exc_cause", 5'd13, 32'h0000_0028);
        rd("exc_epc",   5'd14, 32'h0000_3010);
        rd("exc_sr",    5'd12, 32'h0000_0002);
        check("exc_req_masked", {31'd0, Req}, 32'd0);
        ExcCodeIn = 5'd0; EXLClr = 1'b1;
        tick;
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0000);

        // Delay-slot exception
        ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h0000_3024;
        #1;
        check("bd_req", {31'd0, Req}, 32'd1);
        tick;
        rd("bd_epc",   5'd14, 32'h0000_3020);
        rd("bd_cause", 5'd13, 32'h8000_0010);
        ExcCodeIn = 5'd0; BDIn = 1'b0; EXLClr = 1'b1;
        tick;
        EXLClr = 1'b0;

        // Interrupt beats exception
        En = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
        tick;
        En = 1'b0;
        rd("mtc0_sr", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001; ExcCodeIn = 5'd12; VPC = 32'h0000_3040;
        #1;
        check("int_req", {31'd0, Req}, 32'd1);
        tick;
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr",    5'd12, 32'h0000_0403);
        rd("int_epc",   5'd14, 32'h0000_3040);

        // eret with mtc0 SR setting EXL and clearing IE: eret wins on EXL
        ExcCodeIn = 5'd0; EXLClr = 1'b1; En = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0402;
        #1;
        check("eret_mtc0_noreq", {31'd0, Req}, 32'd0);
        tick;
        EXLClr = 1'b0; En = 1'b0;
        rd("eret_mtc0_sr", 5'd12, 32'h0000_0400);
        ExcCodeIn = 5'd12;
        #1;
        check("ie0_req", {31'd0, Req}, 32'd1);
        tick;
        rd("ie0_cause", 5'd13, 32'h0000_0430);
        rd("ie0_sr",    5'd12, 32'h0000_0402);

        // Flushed mtc0 EPC, then eret re-raises held exception
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b1;
        tick;
        EXLClr = 1'b0;
        En = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234_5678; ExcCodeIn = 5'd8; VPC = 32'h0000_3050;
        #1;
        check("flush_req", {31'd0, Req}, 32'd1);
        tick;
        En = 1'b0;
        rd("flush_epc",   5'd14, 32'h0000_3050);
        rd("flush_cause", 5'd13, 32'h0000_0020);
        EXLClr = 1'b1;
        #1;
        check("eret_held_noreq", {31'd0, Req}, 32'd0);
        tick;
        EXLClr = 1'b0;
        rd("reraise_sr", 5'd12, 32'h0000_0400);
        check("reraise_req", {31'd0, Req}, 32'd1);
        ExcCodeIn = 5'd0;
        #1;
        check("reraise_drop", {31'd0, Req}, 32'd0);

        // Unaligned mtc0 EPC
        tick;
        En = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_3007;
        tick;
        En = 1'b0;
        check("align_epcout", EPCOut, 32'h0000_3004);
        rd("align_epc", 5'd14, 32'h0000_3004);

        // Writes to Cause and PRId are ignored
        En = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
        tick;
        CP0Add = 5'd15;
        tick;
        En = 1'b0;
        rd("ro_cause", 5'd13, 32'h0000_0020);
        rd("ro_prid",  5'd15, 32'h2021_0007);
        rd("ro_epc",   5'd14, 32'h0000_3004);

        // Reset overrides a pending exception
        reset = 1'b1; ExcCodeIn = 5'd3; VPC = 32'h0000_5000;
        tick;
        reset = 1'b0; ExcCodeIn = 5'd0;
        rd("rst2_sr",    5'd12, 32'h0000_0000);
        rd("rst2_cause", 5'd13, 32'h0000_0000);
        check("rst2_epcout", EPCOut, 32'h0000_0000);
        check("rst2_req", {31'd0, Req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. Sits at the M stage.
- Consumes the M-stage exception bundle: PC, ExcCode, BD flag.
- Produces the single-cycle flush request `Req` that every pipeline register (F/D, D/E, E/M, M/W) uses to clear its contents. On `Req`, the E/M register loads PC 0x0000_4180.
- Holds the SR, Cause, EPC and PRId registers for mfc0/mtc0/eret.

Parameters:
- PRID, 32'h2021_0007, read-only value returned for register 15.
- HANDLER_PC, 32'h0000_4180, exception vector; exported on `HandlerPC` for the F-stage PC mux.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- En  in  1  mtc0 write enable from the M stage.
- CP0Add  in  5  register number for mfc0/mtc0.
- CP0In  in  32  mtc0 write data (forwarded M_rt).
- CP0Out  out  32  mfc0 read data, combinational.
- VPC  in  32  M-stage PC (M_pc).
- BDIn  in  1  M-stage instruction is in a delay slot (M_BD).
- ExcCodeIn  in  5  M-stage exception code (M_EXCcode); 0 means none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in the M stage.
- EPCOut  out  32  EPC value for eret redirect.
- HandlerPC  out  32  equals HANDLER_PC.
- Req  out  1  flush/redirect request, combinational.

Behaviour:
- Register fields:
  - SR (12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
- Reset: SR, Cause and EPC are cleared to 0 on a posedge clk with reset=1. Consequently CP0Out=0 (for CP0Add≠15), EPCOut=0 and Req=0 the next cycle. Reset overrides every other input.
- Request logic (combinational):
  - IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
  - ExcReq = (ExcCodeIn≠0) & ~SR.EXL.
  - Req = IntReq | ExcReq.
  - Interrupt has priority over a synchronous exception.
- Exception entry, on posedge when Req=1:
  - SR.EXL<=1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC, with bits [1:0] forced to 0.
  - The mtc0 write in that same cycle is suppressed: the instruction is being flushed.
  - Req is high for exactly one cycle, because EXL=1 masks it afterward.
- Cause.IP <= HWInt every non-reset cycle, independent of EXL and IE.
- mtc0, when En=1 and Req=0:
  - CP0Add=12: writes SR bits [15:10], [1] and [0] from CP0In.
  - CP0Add=14: writes EPC <= {CP0In[31:2], 2'b00}.
  - Any other address, including 13 and 15: no effect.
- eret (EXLClr=1, Req=0): SR.EXL<=0 at the posedge.
- Simultaneous events:
  - mtc0 SR and EXLClr in the same cycle: EXLClr wins for bit 1; the IM and IE bits are still written.
  - EXLClr together with Req cannot arise while EXL=1. If it does arise, Req wins and EXL stays 1.
- Read mux (combinational): 12→SR, 13→Cause, 14→EPC, 15→PRID, otherwise 0. Reads return register state before the current edge; there is no write-to-read bypass.
- EPCOut = EPC register. D-stage eret forwarding of a pending mtc0 EPC is the hazard unit's job, not this block's.
- Latency: Req has zero-cycle latency from its inputs. Register updates land at the next edge.

Test Plan:
- Reset: reset=1 for 1 cycle, then idle → CP0Out@12/13/14 = 0, CP0Out@15 = 32'h2021_0007, Req=0.
- Exception, not in a delay slot: ExcCodeIn=5'd10, VPC=32'h0000_3010, BDIn=0 → Req=1 that cycle. Next cycle: Cause=32'h0000_0028, EPC=32'h0000_3010, SR.EXL=1, Req=0 even though ExcCodeIn is held.
- Delay-slot exception: ExcCodeIn=5'd4, BDIn=1, VPC=32'h0000_3024 → EPC=32'h0000_3020, Cause[31]=1, Cause[6:2]=4.
- Interrupt vs. exception: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 and ExcCodeIn=5'd12 in the same cycle → Req=1, Cause.ExcCode=0, Cause.IP=6'b000001. With IE=0 instead → only the exception fires, ExcCode=12.
- Flushed mtc0 and eret: En=1, CP0Add=14, CP0In=32'h1234_5678, with ExcCodeIn≠0 → EPC=VPC, not 32'h1234_5678. Then EXLClr=1 → SR.EXL=0 and a held exception re-raises Req.
- Unaligned mtc0 EPC: En=1, CP0Add=14, CP0In=32'h0000_3007, no Req → EPC=32'h0000_3004 and EPCOut=32'h0000_3004 the next cycle.
